i2s_rx_core: RTL



---
 rtl/i2s_rx_core_if.sv | 20 ++
 rtl/i2s_rx_core.sv | 125 ++++++++++++
 2 files changed

// File: rtl/i2s_rx_core_if.sv
// i2s_rx_core_if: signal bundle between the I2S receive core and its consumer
// (register wrapper / microphone pins).
//   en    run enable from the consumer
//   DIN   serial data from the microphone
//   BCLK  bit clock to the microphone
//   WS    word select to the microphone (0 = left, 1 = right)
//   data  last captured, sign-extended sample
//   done  one-clk pulse when data has just been updated
// master: consumer side.  slave: the core.
interface i2s_rx_core_if;
    logic        en;
    logic        DIN;
    logic        BCLK;
    logic        WS;
    logic [31:0] data;
    logic        done;

    modport master (output en, DIN, input BCLK, WS, data, done);
    modport slave  (input en, DIN, output BCLK, WS, data, done);
endinterface

// File: rtl/i2s_rx_core.sv
// i2s_rx_core: standard-I2S receiver for one channel of a MEMS microphone.
// Generates BCLK/WS from clk, shifts DATA_BITS MSB-first bits out of the
// selected slot and publishes a sign-extended 32-bit sample with a
// one-clk done pulse. The first frame after enable is thrown away so the
// microphone has time to start up.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    i2s_rx_core_if.slave (en, DIN in; BCLK, WS, data, done out)
// Parameters:
//   CLK_DIV    clk cycles per BCLK half-period (1..255)
//   DATA_BITS  valid bits per slot (1..31)
//   CHANNEL    captured slot, 0 = left (WS=0), 1 = right (WS=1)
module i2s_rx_core #(
    parameter int CLK_DIV   = 8,
    parameter int DATA_BITS = 24,
    parameter int CHANNEL   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    i2s_rx_core_if.slave  bus
);
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]       LSB_POS  = 5'(DATA_BITS);
    localparam logic             CH_WS    = 1'(CHANNEL);

    // IDLE: disabled. PRIME: running, first frame being discarded.
    // RUN: primed, completions are published.
    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;
    state_t state_q, state_d;

    logic [DIV_W-1:0]     div_cnt;
    logic                 bclk_q;
    logic                 ws_q;
    logic [5:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 lsb_pend;   // LSB captured last clk, publish now
    logic [31:0]          data_q;
    logic                 done_q;

    logic                 tick;
    logic                 rise_ev;
    logic                 fall_ev;
    logic                 wrap_ev;
    logic                 cap_ev;
    logic                 last_ev;
    logic [5:0]           bit_nxt;
    logic [4:0]           pos;
    logic [31:0]          sample_sext;

    assign tick    = (div_cnt == DIV_LAST);
    assign rise_ev = bus.en & tick & ~bclk_q;
    assign fall_ev = bus.en & tick &  bclk_q;
    assign bit_nxt = bit_cnt + 6'd1;
    assign wrap_ev = fall_ev & (bit_cnt == 6'd63);
    assign pos     = bit_cnt[4:0];
    // Slot position 0 is the I2S one-bit delay; bits past DATA_BITS are padding.
    assign cap_ev  = rise_ev & (ws_q == CH_WS) & (pos != 5'd0) & (pos <= LSB_POS);
    assign last_ev = cap_ev & (pos == LSB_POS) & (state_q == ST_RUN);

    assign sample_sext = {{(32 - DATA_BITS){shift_q[DATA_BITS-1]}}, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (wrap_ev) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bclk_q   <= 1'b0;
            ws_q     <= 1'b0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            lsb_pend <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else if (!bus.en) begin
            // data deliberately holds its last value while idle
            div_cnt  <= '0;
            bclk_q   <= 1'b0;
            ws_q     <= 1'b0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            lsb_pend <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) bclk_q <= ~bclk_q;
            // WS moves with BCLK falling so it is stable across every rise
            if (fall_ev) begin
                bit_cnt <= bit_nxt;
                ws_q    <= bit_nxt[5];
            end
            lsb_pend <= last_ev;
            done_q   <= lsb_pend;
            if (lsb_pend) begin
                data_q  <= sample_sext;
                shift_q <= '0;
            end else if (cap_ev) begin
                shift_q <= DATA_BITS'({shift_q, bus.DIN});
            end
        end
    end

    assign bus.BCLK = bclk_q;
    assign bus.WS   = ws_q;
    assign bus.data = data_q;
    assign bus.done = done_q;
endmodule
